// File: rtl/matrix_scan_driver.sv
// Time-multiplexes a 128-bit bicolour 8x8 frame onto row/column LED matrix pins.
// A shadow copy of the frame is taken once per scan, and each row starts with a blanking interval.
module matrix_scan_driver #(
    parameter int SCAN_DIV = 5000,
    parameter int BLANK    = 200
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [127:0] matrix_data,
    output logic [7:0]   row_sel,
    output logic [7:0]   col_r,
    output logic [7:0]   col_g,
    output logic         frame_start
);

    localparam int              CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       row_q, row_d;
    logic [127:0]     shadow_q, shadow_d;
    logic             en_q, en_d;
    logic             frame_start_q, frame_start_d;

    logic             tick;
    logic             blank;
    logic [15:0]      row_bits;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d         = cnt_q + 1'b1;
        row_d         = row_q;
        shadow_d      = shadow_q;
        frame_start_d = 1'b0;
        en_d          = en;
        if (tick) begin
            cnt_d = '0;
            row_d = row_q + 3'd1;
            // The frame is captured only as the scan wraps to row 0, so the display never tears.
            if (row_q == 3'd7) begin
                shadow_d      = matrix_data;
                frame_start_d = 1'b1;
            end
        end
    end

    // NOTE: every flop uses non-blocking assignment so all state updates from the same pre-edge values.
    // NOTE: the 128-bit shadow is deliberately reset so the first frame after reset displays blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            row_q         <= '0;
            shadow_q      <= '0;
            en_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            shadow_q      <= shadow_d;
            en_q          <= en_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Signed compare keeps BLANK == 0 meaning "never blank" without a constant-false unsigned test.
    assign blank    = !en_q || (int'(cnt_q) < BLANK);
    assign row_bits = shadow_q[{row_q, 4'b0000} +: 16];

    // NOTE: outputs take their off-state defaults first so no path can infer a latch.
    always_comb begin
        row_sel = 8'hFF;
        col_r   = 8'h00;
        col_g   = 8'h00;
        if (!blank) begin
            row_sel = ~(8'b1 << row_q);
            for (int c = 0; c < 8; c++) begin
                col_r[c] = row_bits[2*c];
                col_g[c] = row_bits[2*c+1];
            end
        end
    end

    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver with SCAN_DIV=4, BLANK=1.
// Expected pins are derived from the cycle count since reset release and the frame known to be on display.
module tb_matrix_scan_driver;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b1;
    logic [127:0] matrix_data = '0;
    logic [7:0]   row_sel, col_r, col_g;
    logic         frame_start;

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;

    localparam logic [127:0] PIX  = 128'h1 << 18;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] PAT  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    matrix_scan_driver #(.SCAN_DIV(4), .BLANK(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .matrix_data (matrix_data),
        .row_sel     (row_sel),
        .col_r       (col_r),
        .col_g       (col_g),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s k=%0d: observed {row_sel,col_r,col_g,fs}=%h expected %h", tag, k, obs, exp);
        end
    endtask

    // Advance n cycles; 'shown' is the frame held in the shadow, 'en_exp' the registered enable.
    task automatic run(input string tag, input int n, input logic [127:0] shown, input bit en_exp);
        int cnt, row;
        logic [7:0] er, eg, ers;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            k++;
            cnt = k % 4;
            row = (k / 4) % 8;
            ers = 8'hFF;
            er  = 8'h00;
            eg  = 8'h00;
            if (en_exp && cnt >= 1) begin
                ers = ~(8'b1 << row);
                for (int c = 0; c < 8; c++) begin
                    er[c] = shown[row*16 + 2*c];
                    eg[c] = shown[row*16 + 2*c + 1];
                end
            end
            check(tag, {row_sel, col_r, col_g, frame_start}, {ers, er, eg, (k % 32) == 0});
        end
    endtask

    initial begin
        // Reset while idle
        #1 rst_n = 1'b0;
        #1 check("reset_async", {row_sel, col_r, col_g, frame_start}, {8'hFF, 8'h00, 8'h00, 1'b0});
        repeat (3) @(negedge clk);
        check("reset_held", {row_sel, col_r, col_g, frame_start}, {8'hFF, 8'h00, 8'h00, 1'b0});
        rst_n = 1'b1;
        k = 0;

        // First frame is blank; frame_start 32 cycles after release
        run("idle_frame", 32, '0, 1'b1);
        matrix_data = PIX;
        run("pre_pixel", 32, '0, 1'b1);
        matrix_data = ONES;
        run("single_pixel", 32, PIX, 1'b1);

        // Change data while row 3 is on; the rest of the frame must stay yellow
        run("yellow_a", 13, ONES, 1'b1);
        matrix_data = '0;
        run("yellow_no_tear", 19, ONES, 1'b1);
        matrix_data = PAT;
        run("zero_frame", 32, '0, 1'b1);
        run("pattern", 32, PAT, 1'b1);

        // Drop enable at row 2 cnt 2, restore at row 3 cnt 2
        run("pre_en_drop", 10, PAT, 1'b1);
        en = 1'b0;
        run("en_low", 4, PAT, 1'b0);
        en = 1'b1;
        run("en_resume", 18, PAT, 1'b1);

        // Asynchronous reset at row 5 cnt 2
        run("pre_reset", 22, PAT, 1'b1);
        rst_n = 1'b0;
        #1 check("midrow_reset_async", {row_sel, col_r, col_g, frame_start}, {8'hFF, 8'h00, 8'h00, 1'b0});
        @(negedge clk);
        check("midrow_reset_held", {row_sel, col_r, col_g, frame_start}, {8'hFF, 8'h00, 8'h00, 1'b0});
        rst_n = 1'b1;
        k = 0;
        run("post_reset_blank", 32, '0, 1'b1);
        run("post_reset_pattern", 32, PAT, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
